// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types and default widths for the I/D cacheline memory arbiter.
package cacheline_mem_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_INST = 1'b0,
      REQ_DATA = 1'b1
   } requester_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } mem_op_t;

endpackage

// File: rtl/cacheline_mem_arbiter_rr_grant2.sv
// Two-requester round-robin picker: a tie goes to the side opposite last_grant,
// which only advances when the caller loads the current grant.
module rr_grant2
   import cacheline_mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_inst,
   input  logic       req_data,
   input  logic       load,
   output requester_t grant
);

   requester_t last_grant;

   always_comb begin
      grant = REQ_INST;
      if (req_inst && req_data) begin
         grant = (last_grant == REQ_DATA) ? REQ_INST : REQ_DATA;
      end else if (req_data) begin
         grant = REQ_DATA;
      end
   end

   // Reset to DATA so the instruction side wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= REQ_DATA;
      end else if (load) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one memory cacheline port between icache and dcache, one transaction
// at a time; the granted request is latched so the memory side stays stable.
module cacheline_mem_arbiter
   import cacheline_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = cacheline_mem_arbiter_pkg::ADDR_W,
   parameter int LINE_W = cacheline_mem_arbiter_pkg::LINE_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   arb_state_t        state_q, state_d;
   requester_t        grant;
   logic              i_req, d_req, load;
   mem_op_t           lat_op;
   logic [ADDR_W-1:0] lat_address;
   logic [LINE_W-1:0] lat_wdata;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   rr_grant2 u_rr (
      .clk      (clk),
      .rst      (rst),
      .req_inst (i_req),
      .req_data (d_req),
      .load     (load),
      .grant    (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lat_op      <= OP_READ;
         lat_address <= '0;
         lat_wdata   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            if (grant == REQ_DATA) begin
               lat_op      <= d_write ? OP_WRITE : OP_READ;
               lat_address <= d_address;
               lat_wdata   <= d_wdata;
            end else begin
               lat_op      <= OP_READ;
               lat_address <= i_address;
               lat_wdata   <= '0;
            end
         end
      end
   end

   // A response arriving in the reset cycle is dropped along with the transaction.
   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      i_resp    = 1'b0;
      d_resp    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               load    = 1'b1;
               state_d = (grant == REQ_INST) ? SERVE_I : SERVE_D;
            end
         end
         SERVE_I: begin
            mem_read = 1'b1;
            if (mem_resp && !rst) begin
               i_resp  = 1'b1;
               state_d = IDLE;
            end
         end
         SERVE_D: begin
            mem_read  = (lat_op == OP_READ);
            mem_write = (lat_op == OP_WRITE);
            if (mem_resp && !rst) begin
               d_resp  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_address = lat_address;
   assign mem_wdata   = lat_wdata;
   assign i_rdata     = mem_rdata;
   assign d_rdata     = mem_rdata;

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(mem_read && mem_write));
         assert (!(i_resp && d_resp));
         assert (!(state_q == IDLE && (mem_read || mem_write)));
         assert (!(state_q == IDLE && d_read && d_write));
      end
   end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: inputs change and outputs are
// sampled around the falling edge, expectations are hand-computed constants.
module tb_cacheline_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;

   int vectors = 0;
   int miscompares = 0;

   logic [LINE_W-1:0] line_a5;
   logic [LINE_W-1:0] line_1234;
   logic [LINE_W-1:0] line_x1;
   logic [LINE_W-1:0] line_x2;

   cacheline_mem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .i_read      (i_read),
      .i_address   (i_address),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_address   (d_address),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
      vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
      vectors++; if ({i_resp, d_resp} !== 2'b00) begin miscompares++; $display("FAIL reset_resp got %b want 00", {i_resp, d_resp}); end
      vectors++; if (mem_address !== '0) begin miscompares++; $display("FAIL reset_mem_address got %h want 0", mem_address); end
      vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
      rst = 1'b0;
   endtask

   task automatic test_inst_read();
      @(negedge clk);
      i_read = 1'b1; i_address = 32'h0000_0060;
      @(negedge clk); #1;
      vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL inst_cmd_read got %b want 1", mem_read); end
      vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL inst_cmd_write got %b want 0", mem_write); end
      vectors++; if (mem_address !== 32'h0000_0060) begin miscompares++; $display("FAIL inst_cmd_addr got %h want 00000060", mem_address); end
      repeat (2) begin
         @(negedge clk); #1;
         vectors++; if ({mem_read, i_resp} !== 2'b10) begin miscompares++; $display("FAIL inst_wait got read/resp %b want 10", {mem_read, i_resp}); end
      end
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = line_a5;
      #1;
      vectors++; if (i_resp !== 1'b1) begin miscompares++; $display("FAIL inst_resp got %b want 1", i_resp); end
      vectors++; if (i_rdata !== line_a5) begin miscompares++; $display("FAIL inst_rdata got %h want %h", i_rdata, line_a5); end
      vectors++; if (d_resp !== 1'b0) begin miscompares++; $display("FAIL inst_d_resp got %b want 0", d_resp); end
      @(negedge clk);
      mem_resp = 1'b0; i_read = 1'b0; mem_rdata = '0;
      #1;
      vectors++; if ({mem_read, i_resp} !== 2'b00) begin miscompares++; $display("FAIL inst_after got read/resp %b want 00", {mem_read, i_resp}); end
   endtask

   task automatic test_data_write();
      @(negedge clk);
      d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = line_1234;
      @(negedge clk); #1;
      vectors++; if ({mem_read, mem_write} !== 2'b01) begin miscompares++; $display("FAIL dwr_cmd got read/write %b want 01", {mem_read, mem_write}); end
      vectors++; if (mem_address !== 32'h0000_1000) begin miscompares++; $display("FAIL dwr_addr got %h want 00001000", mem_address); end
      vectors++; if (mem_wdata !== line_1234) begin miscompares++; $display("FAIL dwr_wdata got %h want %h", mem_wdata, line_1234); end
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      vectors++; if ({mem_read, mem_write, mem_wdata == line_1234} !== 3'b011) begin miscompares++; $display("FAIL dwr_hold got read/write/wdata_ok %b want 011", {mem_read, mem_write, mem_wdata == line_1234}); end
      vectors++; if ({i_resp, d_resp} !== 2'b01) begin miscompares++; $display("FAIL dwr_resp got i/d %b want 01", {i_resp, d_resp}); end
      @(negedge clk);
      mem_resp = 1'b0; d_write = 1'b0;
      #1;
      vectors++; if ({mem_write, d_resp} !== 2'b00) begin miscompares++; $display("FAIL dwr_after got write/resp %b want 00", {mem_write, d_resp}); end
   endtask

   task automatic test_tie_round_robin();
      apply_reset();
      @(negedge clk);
      i_read = 1'b1; i_address = 32'h40; d_read = 1'b1; d_address = 32'h80;
      @(negedge clk); #1;
      vectors++; if ({mem_read, mem_address} !== {1'b1, 32'h40}) begin miscompares++; $display("FAIL tie1_first got read=%b addr=%h want 1/00000040", mem_read, mem_address); end
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = line_x1;
      #1;
      vectors++; if ({i_resp, d_resp, i_rdata == line_x1} !== 3'b101) begin miscompares++; $display("FAIL tie1_resp got i/d/data_ok %b want 101", {i_resp, d_resp, i_rdata == line_x1}); end
      // icache immediately re-requests, so the bubble samples a second tie
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      vectors++; if ({mem_read, mem_write, i_resp} !== 3'b000) begin miscompares++; $display("FAIL tie_bubble got read/write/resp %b want 000", {mem_read, mem_write, i_resp}); end
      @(negedge clk); #1;
      vectors++; if ({mem_read, mem_address} !== {1'b1, 32'h80}) begin miscompares++; $display("FAIL tie2_data_first got read=%b addr=%h want 1/00000080", mem_read, mem_address); end
      @(negedge clk);
      d_address = 32'hC0;
      #1;
      vectors++; if (mem_address !== 32'h80) begin miscompares++; $display("FAIL addr_latched got %h want 00000080", mem_address); end
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = line_x2;
      #1;
      vectors++; if ({i_resp, d_resp, d_rdata == line_x2} !== 3'b011) begin miscompares++; $display("FAIL tie2_resp got i/d/data_ok %b want 011", {i_resp, d_resp, d_rdata == line_x2}); end
      vectors++; if (mem_address !== 32'h80) begin miscompares++; $display("FAIL addr_latched_resp got %h want 00000080", mem_address); end
      @(negedge clk);
      mem_resp = 1'b0; d_read = 1'b0;
      #1;
      vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL tie2_bubble got %b want 0", mem_read); end
      @(negedge clk); #1;
      vectors++; if ({mem_read, mem_address} !== {1'b1, 32'h40}) begin miscompares++; $display("FAIL waiting_inst got read=%b addr=%h want 1/00000040", mem_read, mem_address); end
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      vectors++; if ({i_resp, d_resp} !== 2'b10) begin miscompares++; $display("FAIL waiting_inst_resp got %b want 10", {i_resp, d_resp}); end
      @(negedge clk);
      mem_resp = 1'b0; i_read = 1'b0;
      #1;
      vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL tie_end got %b want 0", mem_read); end
   endtask

   task automatic test_reset_mid_transaction();
      @(negedge clk);
      d_read = 1'b1; d_address = 32'h100;
      @(negedge clk); #1;
      vectors++; if ({mem_read, mem_address} !== {1'b1, 32'h100}) begin miscompares++; $display("FAIL rmid_serve got read=%b addr=%h want 1/00000100", mem_read, mem_address); end
      @(negedge clk);
      rst = 1'b1; mem_resp = 1'b1;
      #1;
      vectors++; if (d_resp !== 1'b0) begin miscompares++; $display("FAIL rmid_no_resp_in_rst got %b want 0", d_resp); end
      @(negedge clk);
      rst = 1'b0; mem_resp = 1'b0; i_read = 1'b1; i_address = 32'h200;
      #1;
      vectors++; if ({mem_read, mem_write, d_resp, i_resp} !== 4'b0000) begin miscompares++; $display("FAIL rmid_drop got read/write/dresp/iresp %b want 0000", {mem_read, mem_write, d_resp, i_resp}); end
      @(negedge clk); #1;
      vectors++; if ({mem_read, mem_address} !== {1'b1, 32'h200}) begin miscompares++; $display("FAIL rmid_tie_inst got read=%b addr=%h want 1/00000200", mem_read, mem_address); end
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      vectors++; if ({i_resp, d_resp} !== 2'b10) begin miscompares++; $display("FAIL rmid_inst_resp got %b want 10", {i_resp, d_resp}); end
      @(negedge clk);
      mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
      @(negedge clk); #1;
      vectors++; if ({mem_read, mem_write} !== 2'b00) begin miscompares++; $display("FAIL rmid_idle got %b want 00", {mem_read, mem_write}); end
   endtask

   task automatic test_spurious_resp();
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = line_a5;
      #1;
      vectors++; if ({i_resp, d_resp} !== 2'b00) begin miscompares++; $display("FAIL spurious_resp got %b want 00", {i_resp, d_resp}); end
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      vectors++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin miscompares++; $display("FAIL spurious_after got %b want 0000", {mem_read, mem_write, i_resp, d_resp}); end
   endtask

   initial begin
      line_a5   = {32{8'hA5}};
      line_1234 = {8{32'h1234_5678}};
      line_x1   = {8{32'hCAFE_0001}};
      line_x2   = {8{32'hBEEF_0002}};
      test_reset();
      test_inst_read();
      test_data_write();
      test_tie_round_robin();
      test_reset_mid_transaction();
      test_spurious_resp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
